mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_pkg.sv | 58 +++++
 rtl/mc_controller_if.sv | 35 +++
 rtl/imm_src_decoder.sv | 21 ++
 rtl/mc_controller.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// opcode values, immediate-format codes and datapath mux select codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BRANCH,
        S_UTYPE,
        S_ILLEGAL
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ALU operand A: PC, OldPC, rs1, constant zero (LUI)
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    function automatic logic is_utype(input logic [6:0] opc);
        return (opc == OPC_LUI) || (opc == OPC_AUIPC);
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between the multicycle controller and its datapath/memory.
interface mc_controller_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       Opcode;
    logic [2:0]       funct3;
    logic             Zero;
    logic             MemReady;

    logic             PCWrite;
    logic             AdrSrc;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [2:0]       ImmSrc;
    logic             IllegalInstr;
    logic [CNT_W-1:0] InstRet;

    modport master (
        input  Opcode, funct3, Zero, MemReady,
        output PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, IllegalInstr, InstRet
    );

    modport slave (
        output Opcode, funct3, Zero, MemReady,
        input  PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, IllegalInstr, InstRet
    );
endinterface

// File: rtl/imm_src_decoder.sv
// Immediate-format select, decoded purely from the opcode so it is valid
// in every FSM state.
module imm_src_decoder
    import mc_pkg::*;
(
    input  logic [6:0] Opcode,
    output logic [2:0] ImmSrc
);

    always_comb begin
        ImmSrc = IMM_I;
        case (Opcode)
            OPC_STORE:           ImmSrc = IMM_S;
            OPC_BRANCH:          ImmSrc = IMM_B;
            OPC_JAL:             ImmSrc = IMM_J;
            OPC_LUI, OPC_AUIPC:  ImmSrc = IMM_U;
            default:             ImmSrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore-style multicycle RISC-V controller with memory stall handling,
// illegal-opcode trap pulse and a retired-instruction counter.
module mc_controller
    import mc_pkg::*;
#(
    parameter bit EXT_U = 1'b1,
    parameter int CNT_W = 32
) (
    input logic            clk,
    input logic            rst,
    mc_controller_if.master bus
);

    state_t           state;
    state_t           next_state;
    state_t           out_state;
    logic             pc_update;
    logic             branch;
    logic             retire;
    logic [CNT_W-1:0] inst_ret;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (bus.MemReady) next_state = S_DECODE;
            S_DECODE: begin
                case (bus.Opcode)
                    OPC_LOAD, OPC_STORE: next_state = S_MEMADR;
                    OPC_RTYPE:           next_state = S_EXECR;
                    OPC_ITYPE:           next_state = S_EXECI;
                    OPC_JAL:             next_state = S_JAL;
                    OPC_BRANCH:          next_state = S_BRANCH;
                    OPC_LUI, OPC_AUIPC:  next_state = EXT_U ? S_UTYPE : S_ILLEGAL;
                    default:             next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   next_state = (bus.Opcode == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.MemReady) next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: if (bus.MemReady) next_state = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_UTYPE: next_state = S_ALUWB;
            S_ALUWB, S_BRANCH, S_ILLEGAL:     next_state = S_FETCH;
            default:    next_state = S_FETCH;
        endcase
    end

    // Outputs decode from FETCH while reset is held so the datapath sees
    // fetch controls during reset, not whatever state was interrupted.
    assign out_state = rst ? S_FETCH : state;

    always_comb begin
        pc_update        = 1'b0;
        branch           = 1'b0;
        bus.AdrSrc       = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.ResultSrc    = RES_ALUOUT;
        bus.ALUSrcA      = SRCA_PC;
        bus.ALUSrcB      = SRCB_REG;
        bus.ALUOp        = ALUOP_ADD;
        bus.IllegalInstr = 1'b0;
        case (out_state)
            S_FETCH: begin
                bus.MemRead   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALU;
                bus.IRWrite   = bus.MemReady;
                pc_update     = bus.MemReady;
            end
            S_DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                bus.MemRead = 1'b1;
                bus.AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.MemWrite = 1'b1;
                bus.AdrSrc   = 1'b1;
            end
            S_EXECR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_REG;
                bus.ALUOp   = ALUOP_FUNC;
            end
            S_EXECI: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ALUOp   = ALUOP_FUNC;
            end
            S_ALUWB:   bus.RegWrite = 1'b1;
            S_JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                pc_update   = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_REG;
                bus.ALUOp   = ALUOP_SUB;
                branch      = 1'b1;
            end
            S_UTYPE: begin
                bus.ALUSrcA = (bus.Opcode == OPC_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_ILLEGAL: bus.IllegalInstr = 1'b1;
            default: ;
        endcase
    end

    // funct3[0] distinguishes bne from beq, inverting the sense of Zero.
    assign bus.PCWrite = pc_update | (branch & (bus.Zero ^ bus.funct3[0]));

    assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
                    ((state == S_MEMWRITE) && bus.MemReady);

    always_ff @(posedge clk) begin
        if (rst)         inst_ret <= '0;
        else if (retire) inst_ret <= inst_ret + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign bus.InstRet = inst_ret;

    imm_src_decoder u_imm_src_decoder (
        .Opcode (bus.Opcode),
        .ImmSrc (bus.ImmSrc)
    );

endmodule
